// File: rtl/seq_stream_sched.sv
`default_nettype none
//============================================================================
// Module : seq_stream_sched
// Brief  : Round-robin scheduler sharing one 1011 detector over NCH serial
//          bit-stream channels, with per-channel saturating match counters.
// Rev    : 1.0 - initial release
//============================================================================
module seq_stream_sched #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req_valid,
  input  logic [NCH-1:0]         req_bit,
  output logic [NCH-1:0]         req_ready,
  input  logic [NCH-1:0]         clr_ch,
  output logic                   match_valid,
  output logic [$clog2(NCH)-1:0] match_ch,
  input  logic [$clog2(NCH)-1:0] cnt_sel,
  output logic [CNT_W-1:0]       cnt_out
);

  localparam int                 c_sel_w   = $clog2(NCH);
  localparam logic [c_sel_w:0]   c_nch     = (c_sel_w+1)'(NCH);
  localparam logic [CNT_W-1:0]   c_cnt_max = '1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_s1   = 2'd1;
  localparam logic [1:0] c_st_s10  = 2'd2;
  localparam logic [1:0] c_st_s101 = 2'd3;

  logic [1:0]         r_state     [NCH];
  logic [1:0]         w_state_nxt [NCH];
  logic [CNT_W-1:0]   r_cnt       [NCH];
  logic [c_sel_w-1:0] r_ptr;
  logic               r_match_valid;
  logic [c_sel_w-1:0] r_match_ch;

  logic [NCH-1:0]     w_eligible;
  logic               w_xfer;
  logic [c_sel_w-1:0] w_grant;
  logic [c_sel_w-1:0] w_ptr_nxt;
  logic               w_bit;
  logic               w_match;

  // Nothing is offered a grant while reset is held.
  assign w_eligible = reset ? '0 : (req_valid & ~clr_ch);

  // First eligible channel at or after the pointer, wrapping at NCH-1.
  always_comb begin
    logic [c_sel_w:0] cand;
    w_xfer  = 1'b0;
    w_grant = '0;
    cand    = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = {1'b0, r_ptr} + (c_sel_w+1)'(k);
      if (cand >= c_nch) begin
        cand = cand - c_nch;
      end
      if (!w_xfer && w_eligible[cand[c_sel_w-1:0]]) begin
        w_xfer  = 1'b1;
        w_grant = cand[c_sel_w-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_xfer) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  assign w_bit     = req_bit[w_grant];
  assign w_ptr_nxt = ({1'b0, w_grant} == c_nch - 1'b1) ? '0 : w_grant + 1'b1;

  // Detector state register, one 2-bit state per channel.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        r_state[i] <= c_st_idle;
      end else begin
        r_state[i] <= w_state_nxt[i];
      end
    end
  end

  // Only the granted channel advances; a cleared channel is never granted.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
    end
    if (w_xfer) begin
      case (r_state[w_grant])
        c_st_idle: w_state_nxt[w_grant] = w_bit ? c_st_s1   : c_st_idle;
        c_st_s1:   w_state_nxt[w_grant] = w_bit ? c_st_s1   : c_st_s10;
        c_st_s10:  w_state_nxt[w_grant] = w_bit ? c_st_s101 : c_st_idle;
        c_st_s101: w_state_nxt[w_grant] = w_bit ? c_st_idle : c_st_s10;
        default:   w_state_nxt[w_grant] = c_st_idle;
      endcase
    end
    for (int i = 0; i < NCH; i++) begin
      if (clr_ch[i]) begin
        w_state_nxt[i] = c_st_idle;
      end
    end
  end

  always_comb begin
    w_match = w_xfer && w_bit && (r_state[w_grant] == c_st_s101);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (reset || clr_ch[i]) begin
        r_cnt[i] <= '0;
      end else if (w_match && (w_grant == c_sel_w'(i)) && (r_cnt[i] != c_cnt_max)) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr         <= '0;
      r_match_valid <= 1'b0;
      r_match_ch    <= '0;
    end else begin
      if (w_xfer) begin
        r_ptr <= w_ptr_nxt;
      end
      r_match_valid <= w_match;
      r_match_ch    <= w_match ? w_grant : '0;
    end
  end

  assign match_valid = r_match_valid;
  assign match_ch    = r_match_ch;
  assign cnt_out     = ({1'b0, cnt_sel} < c_nch) ? r_cnt[cnt_sel] : '0;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));
  a_match_ch_idle: assert property (@(posedge clk) !match_valid |-> (match_ch == '0));

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_sched.sv
`default_nettype none
//============================================================================
// Module : tb_seq_stream_sched
// Brief  : Randomized and directed bench for seq_stream_sched against a
//          history-based reference model (three parameter sets in parallel).
// Rev    : 1.0 - initial release
//============================================================================
module tb_seq_stream_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid, req_bit, clr_ch;
  logic [1:0] cnt_sel;

  logic [3:0] rdy_a, rdy_b;
  logic [2:0] rdy_c;
  logic       mv_a, mv_b, mv_c;
  logic [1:0] mc_a, mc_b, mc_c;
  logic [7:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  seq_stream_sched #(.NCH(4), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_bit(req_bit),
    .req_ready(rdy_a), .clr_ch(clr_ch), .match_valid(mv_a), .match_ch(mc_a),
    .cnt_sel(cnt_sel), .cnt_out(cnt_a));

  seq_stream_sched #(.NCH(4), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_bit(req_bit),
    .req_ready(rdy_b), .clr_ch(clr_ch), .match_valid(mv_b), .match_ch(mc_b),
    .cnt_sel(cnt_sel), .cnt_out(cnt_b));

  seq_stream_sched #(.NCH(3), .CNT_W(8)) u_c (
    .clk(clk), .reset(reset), .req_valid(req_valid[2:0]), .req_bit(req_bit[2:0]),
    .req_ready(rdy_c), .clr_ch(clr_ch[2:0]), .match_valid(mv_c), .match_ch(mc_c),
    .cnt_sel(cnt_sel), .cnt_out(cnt_c));

  logic [3:0] obs_rdy [3];
  logic       obs_mv  [3];
  logic [1:0] obs_mc  [3];
  logic [7:0] obs_cnt [3];

  assign obs_rdy[0] = rdy_a;
  assign obs_rdy[1] = rdy_b;
  assign obs_rdy[2] = {1'b0, rdy_c};
  assign obs_mv[0]  = mv_a;
  assign obs_mv[1]  = mv_b;
  assign obs_mv[2]  = mv_c;
  assign obs_mc[0]  = mc_a;
  assign obs_mc[1]  = mc_b;
  assign obs_mc[2]  = mc_c;
  assign obs_cnt[0] = cnt_a;
  assign obs_cnt[1] = {6'b0, cnt_b};
  assign obs_cnt[2] = cnt_c;

  // Reference model: per channel, the bits accepted since the last match or
  // clear; a match is the last four of those bits reading 1011.
  localparam int c_n   [3] = '{4, 4, 3};
  localparam int c_max [3] = '{255, 3, 255};

  int m_ptr [3];
  int m_len [3][4];
  int m_sh  [3][4];
  int m_cnt [3][4];
  int m_mv  [3];
  int m_mc  [3];

  logic [3:0] e_rdy [3];
  int         e_g   [3];
  int         e_mv  [3];
  int         e_mc  [3];
  int         e_cnt [3];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int pick(int u, logic rst, logic [3:0] v, logic [3:0] c);
    if (rst) return -1;
    for (int k = 0; k < c_n[u]; k++) begin
      int ch;
      ch = (m_ptr[u] + k) % c_n[u];
      if (v[ch] && !c[ch]) return ch;
    end
    return -1;
  endfunction

  task automatic drive(input logic rst, input logic [3:0] v, input logic [3:0] b,
                       input logic [3:0] c, input logic [1:0] sel);
    @(negedge clk);
    reset = rst; req_valid = v; req_bit = b; clr_ch = c; cnt_sel = sel;
    #1;
    for (int u = 0; u < 3; u++) begin
      e_g[u]   = pick(u, rst, v, c);
      e_rdy[u] = (e_g[u] >= 0) ? 4'(1 << e_g[u]) : 4'd0;
      e_mv[u]  = m_mv[u];
      e_mc[u]  = m_mc[u];
      e_cnt[u] = (int'(sel) < c_n[u]) ? m_cnt[u][sel] : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int u = 0; u < 3; u++) begin
      if (reset) begin
        m_ptr[u] = 0; m_mv[u] = 0; m_mc[u] = 0;
        for (int ch = 0; ch < 4; ch++) begin
          m_len[u][ch] = 0; m_sh[u][ch] = 0; m_cnt[u][ch] = 0;
        end
      end else begin
        int g;
        g = e_g[u];
        m_mv[u] = 0;
        m_mc[u] = 0;
        if (g >= 0) begin
          m_sh[u][g]  = ((m_sh[u][g] << 1) | int'(req_bit[g])) & 15;
          m_len[u][g] = m_len[u][g] + 1;
          if (m_len[u][g] >= 4 && m_sh[u][g] == 11) begin
            m_mv[u] = 1;
            m_mc[u] = g;
            if (m_cnt[u][g] < c_max[u]) m_cnt[u][g] = m_cnt[u][g] + 1;
            m_len[u][g] = 0;
            m_sh[u][g]  = 0;
          end
          m_ptr[u] = (g + 1) % c_n[u];
        end
        for (int ch = 0; ch < c_n[u]; ch++) begin
          if (clr_ch[ch]) begin
            m_len[u][ch] = 0; m_sh[u][ch] = 0; m_cnt[u][ch] = 0;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
    tick();
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 4'b0, 4'b0, 4'b0, 2'(s));
      n_cmp++;
      if (rdy_a !== 4'b0 || rdy_b !== 4'b0 || rdy_c !== 3'b0) begin
        n_bad++; $display("FAIL reset_ready: got %b/%b/%b want 0", rdy_a, rdy_b, rdy_c);
      end
      n_cmp++;
      if (mv_a !== 1'b0 || mv_b !== 1'b0 || mv_c !== 1'b0 || mc_a !== 2'd0 || mc_b !== 2'd0 || mc_c !== 2'd0) begin
        n_bad++; $display("FAIL reset_match: got v%b%b%b ch%0d%0d%0d want 0", mv_a, mv_b, mv_c, mc_a, mc_b, mc_c);
      end
      n_cmp++;
      if (cnt_a !== 8'd0 || cnt_b !== 2'd0 || cnt_c !== 8'd0) begin
        n_bad++; $display("FAIL reset_cnt sel%0d: got %0d/%0d/%0d want 0", s, cnt_a, cnt_b, cnt_c);
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic [3:0] pat;
    pat = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0001, {3'b0, pat[3-i]}, 4'b0, 2'd0);
      n_cmp++;
      if (rdy_a !== 4'b0001) begin
        n_bad++; $display("FAIL single_ready[%0d]: got %b want 0001", i, rdy_a);
      end
      tick();
    end
    drive(1'b0, 4'b0, 4'b0, 4'b0, 2'd0);
    n_cmp++;
    if (mv_a !== 1'b1 || mc_a !== 2'd0) begin
      n_bad++; $display("FAIL single_match: got v%b ch%0d want v1 ch0", mv_a, mc_a);
    end
    n_cmp++;
    if (cnt_a !== 8'd1) begin
      n_bad++; $display("FAIL single_cnt: got %0d want 1", cnt_a);
    end
    tick();
    drive(1'b0, 4'b0, 4'b0, 4'b0, 2'd0);
    n_cmp++;
    if (mv_a !== 1'b0) begin
      n_bad++; $display("FAIL single_pulse_width: got %b want 0", mv_a);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] pat;
    pat = 4'b1011;
    drive(1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
    tick();
    for (int t = 0; t < 16; t++) begin
      drive(1'b0, 4'b1111, {1'b0, pat[3 - t/4], 2'b00}, 4'b0, 2'd2);
      n_cmp++;
      if (rdy_a !== 4'(1 << (t % 4))) begin
        n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", t, rdy_a, 4'(1 << (t % 4)));
      end
      n_cmp++;
      if (mv_a !== (t == 15)) begin
        n_bad++; $display("FAIL rr_match[%0d]: got %b want %b", t, mv_a, (t == 15));
      end
      if (t == 15) begin
        n_cmp++;
        if (mc_a !== 2'd2 || cnt_a !== 8'd1) begin
          n_bad++; $display("FAIL rr_match_ch: got ch%0d cnt%0d want ch2 cnt1", mc_a, cnt_a);
        end
      end
      tick();
    end
  endtask

  task automatic test_non_overlap();
    logic [6:0] s1;
    logic [5:0] s2;
    int hits;
    s1 = 7'b1011011;
    s2 = 6'b101011;
    drive(1'b1, 4'b0, 4'b0, 4'b0, 2'd1);
    tick();
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, (i < 7) ? 4'b0010 : 4'b0, {2'b0, (i < 7) ? s1[6-i] : 1'b0, 1'b0}, 4'b0, 2'd1);
      if (mv_a === 1'b1) hits++;
      tick();
    end
    n_cmp++;
    if (hits != 1) begin
      n_bad++; $display("FAIL nonoverlap_hits: got %0d want 1", hits);
    end
    hits = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, (i < 6) ? 4'b0010 : 4'b0, {2'b0, (i < 6) ? s2[5-i] : 1'b0, 1'b0}, 4'b0, 2'd1);
      if (mv_a === 1'b1) hits++;
      tick();
    end
    n_cmp++;
    if (hits != 1) begin
      n_bad++; $display("FAIL s101_s10_hits: got %0d want 1", hits);
    end
    drive(1'b0, 4'b0, 4'b0, 4'b0, 2'd1);
    n_cmp++;
    if (cnt_a !== 8'd2) begin
      n_bad++; $display("FAIL nonoverlap_cnt: got %0d want 2", cnt_a);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [3:0] pat;
    pat = 4'b1011;
    drive(1'b1, 4'b0, 4'b0, 4'b0, 2'd3);
    tick();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 4'b1000, {pat[3-i], 3'b0}, 4'b0, 2'd3);
        tick();
      end
    end
    drive(1'b0, 4'b0, 4'b0, 4'b0, 2'd3);
    n_cmp++;
    if (cnt_b !== 2'd3) begin
      n_bad++; $display("FAIL sat_cnt_w2: got %0d want 3", cnt_b);
    end
    n_cmp++;
    if (cnt_a !== 8'd5) begin
      n_bad++; $display("FAIL sat_cnt_w8: got %0d want 5", cnt_a);
    end
    tick();
  endtask

  task automatic test_clear();
    logic [6:0] s;
    s = 7'b1011101;
    drive(1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 4'b0001, {3'b0, s[6-i]}, 4'b0, 2'd0);
      tick();
    end
    drive(1'b0, 4'b0011, 4'b0001, 4'b0001, 2'd0);
    n_cmp++;
    if (rdy_a !== 4'b0010) begin
      n_bad++; $display("FAIL clear_ready: got %b want 0010", rdy_a);
    end
    n_cmp++;
    if (cnt_a !== 8'd1) begin
      n_bad++; $display("FAIL clear_cnt_before: got %0d want 1", cnt_a);
    end
    tick();
    drive(1'b0, 4'b0, 4'b0, 4'b0, 2'd0);
    n_cmp++;
    if (mv_a !== 1'b0 || cnt_a !== 8'd0) begin
      n_bad++; $display("FAIL clear_effect: got v%b cnt%0d want v0 cnt0", mv_a, cnt_a);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0001, {3'b0, s[6-i]}, 4'b0, 2'd0);
      tick();
    end
    drive(1'b0, 4'b0, 4'b0, 4'b0, 2'd0);
    n_cmp++;
    if (mv_a !== 1'b1 || mc_a !== 2'd0 || cnt_a !== 8'd1) begin
      n_bad++; $display("FAIL clear_rematch: got v%b ch%0d cnt%0d want v1 ch0 cnt1", mv_a, mc_a, cnt_a);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [2:0] s;
    s = 3'b101;
    drive(1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b0010 | 4'b0001, {3'b0, s[2-i]}, 4'b0, 2'd0);
      tick();
    end
    drive(1'b1, 4'b0001, 4'b0001, 4'b0, 2'd0);
    n_cmp++;
    if (rdy_a !== 4'b0 || rdy_b !== 4'b0 || rdy_c !== 3'b0) begin
      n_bad++; $display("FAIL rstmid_ready: got %b/%b/%b want 0", rdy_a, rdy_b, rdy_c);
    end
    tick();
    drive(1'b0, 4'b1111, 4'b0001, 4'b0, 2'd0);
    n_cmp++;
    if (rdy_a !== 4'b0001) begin
      n_bad++; $display("FAIL rstmid_ptr: got %b want 0001", rdy_a);
    end
    tick();
    drive(1'b0, 4'b0, 4'b0, 4'b0, 2'd0);
    n_cmp++;
    if (mv_a !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_nomatch: got %b want 0", mv_a);
    end
    tick();
  endtask

  task automatic test_random();
    drive(1'b1, 4'b0, 4'b0, 4'b0, 2'd0);
    tick();
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(63) == 0), 4'($urandom), 4'($urandom),
            4'($urandom & $urandom & $urandom), 2'($urandom));
      for (int u = 0; u < 3; u++) begin
        n_cmp++;
        if (obs_rdy[u] !== e_rdy[u]) begin
          n_bad++; $display("FAIL rand_ready u%0d cyc%0d: got %b want %b", u, n, obs_rdy[u], e_rdy[u]);
        end
        n_cmp++;
        if (obs_mv[u] !== 1'(e_mv[u]) || obs_mc[u] !== 2'(e_mc[u])) begin
          n_bad++; $display("FAIL rand_match u%0d cyc%0d: got v%b ch%0d want v%0d ch%0d",
                            u, n, obs_mv[u], obs_mc[u], e_mv[u], e_mc[u]);
        end
        n_cmp++;
        if (obs_cnt[u] !== 8'(e_cnt[u])) begin
          n_bad++; $display("FAIL rand_cnt u%0d cyc%0d sel%0d: got %0d want %0d", u, n, cnt_sel, obs_cnt[u], e_cnt[u]);
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_bit = '0; clr_ch = '0; cnt_sel = '0;
    for (int u = 0; u < 3; u++) begin
      m_ptr[u] = 0; m_mv[u] = 0; m_mc[u] = 0; e_g[u] = -1;
      for (int ch = 0; ch < 4; ch++) begin
        m_len[u][ch] = 0; m_sh[u][ch] = 0; m_cnt[u][ch] = 0;
      end
    end
    test_reset();
    test_single();
    test_round_robin();
    test_non_overlap();
    test_saturation();
    test_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
